// File: rtl/mem_access_ctrl_if.sv
// Execute-stage / data-memory bundle seen by the memory-stage access controller.
// The slave modport is the controller's view; master is the pipeline + memory side.
`timescale 1ns/1ps
`default_nettype none

interface mem_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // Execute-stage request
    logic              mem_enable_in;
    logic              mem_write_en_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;

    // Memory handshake
    logic              mem_stall_in;
    logic              mem_done_in;
    logic [DATA_W-1:0] mem_rdata_in;
    logic              mem_rd_out;
    logic              mem_wr_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;

    // Writeback / pipeline control
    logic [DATA_W-1:0] read_data_out;
    logic              freeze_out;
    logic              err_out;

    modport slave (
        input  mem_enable_in, mem_write_en_in, addr_in, wdata_in,
        input  mem_stall_in, mem_done_in, mem_rdata_in,
        output mem_rd_out, mem_wr_out, mem_addr_out, mem_wdata_out,
        output read_data_out, freeze_out, err_out
    );

    modport master (
        output mem_enable_in, mem_write_en_in, addr_in, wdata_in,
        output mem_stall_in, mem_done_in, mem_rdata_in,
        input  mem_rd_out, mem_wr_out, mem_addr_out, mem_wdata_out,
        input  read_data_out, freeze_out, err_out
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one request per access, freezes the pipeline
// until done/timeout. Optional macro ALIGN_CHECK_EN rejects odd addresses in IDLE.
`timescale 1ns/1ps
`default_nettype none

module mem_access_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  wire logic          clk,
    input  wire logic          global_rst_n,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd;
    logic              r_wr;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_misaligned;
    logic              w_latch;
    logic              w_align_err;
    logic              w_timeout;
    logic              w_done_hit;
    logic              w_freeze;
    logic              w_we_next;
    logic [CNT_W-1:0]  w_cnt_inc;

`ifdef ALIGN_CHECK_EN
    assign w_misaligned = bus.addr_in[0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_align_err  = 1'b0;
        w_timeout    = 1'b0;
        w_done_hit   = 1'b0;
        w_freeze     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.mem_enable_in) begin
                    w_freeze = 1'b1;
                    if (w_misaligned) begin
                        w_align_err  = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_freeze = 1'b1;
                if (!bus.mem_stall_in) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_freeze = 1'b1;
                // A done arriving on the final allowed cycle beats the timeout.
                if (bus.mem_done_in) begin
                    w_done_hit   = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_cnt_inc == TIMEOUT_VAL) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Direction of the request about to be presented (freshly latched or held).
    assign w_we_next = w_latch ? bus.mem_write_en_in : r_we;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_latch) begin
                r_we    <= bus.mem_write_en_in;
                r_addr  <= bus.addr_in;
                r_wdata <= bus.wdata_in;
            end

            // Request strobes are registered and high for exactly the REQ cycles.
            r_rd <= (w_state_next == S_REQ) && !w_we_next;
            r_wr <= (w_state_next == S_REQ) &&  w_we_next;

            if (r_state == S_REQ) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_done_hit && !r_we) begin
                r_rdata <= bus.mem_rdata_in;
            end

            if (w_timeout || w_align_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_rd_out    = r_rd;
    assign bus.mem_wr_out    = r_wr;
    assign bus.mem_addr_out  = r_addr;
    assign bus.mem_wdata_out = r_wdata;
    assign bus.read_data_out = r_rdata;
    assign bus.err_out       = r_err;
    // Gated by reset so every output reads 0 while reset is held.
    assign bus.freeze_out    = global_rst_n & w_freeze;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes per-access expectations from a
// cycle-count model; a monitor pops and compares at the end of each freeze window.
`timescale 1ns/1ps

module tb_mem_access_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 64;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic global_rst_n = 1'b0;

    mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)
    ) dut (
        .clk(clk),
        .global_rst_n(global_rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          freeze;
        int          rd;
        int          wr;
        int          gap;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_wdata = '0;
    int          next_gap = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one comparison set per completed freeze window.
    initial begin : monitor
        int   frz_cnt = 0;
        int   rd_cnt  = 0;
        int   wr_cnt  = 0;
        int   low_run = -1;
        int   gap     = -1;
        bit   prev    = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!global_rst_n) begin
                frz_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                low_run = -1; gap = -1; prev = 1'b0;
                continue;
            end
            rd_cnt += int'(bus.mem_rd_out);
            wr_cnt += int'(bus.mem_wr_out);
            if (bus.freeze_out === 1'b1) begin
                if (!prev) gap = low_run;
                frz_cnt++;
            end else if (prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion actual=window required=none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("freeze_cycles", frz_cnt, e.freeze);
                    check("rd_cycles", rd_cnt, e.rd);
                    check("wr_cycles", wr_cnt, e.wr);
                    check("read_data", bus.read_data_out, e.rdata);
                    check("err", bus.err_out, e.err);
                    check("mem_addr", bus.mem_addr_out, e.addr);
                    check("mem_wdata", bus.mem_wdata_out, e.wdata);
                    if (e.gap >= 0) check("unfrozen_gap", gap, e.gap);
                end
                frz_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                low_run = 1;
            end else if (low_run >= 0) begin
                low_run++;
            end
            prev = (bus.freeze_out === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        if (next_gap >= 0) next_gap += n;
    endtask

    // Called one time unit after a rising edge with the DUT in IDLE; returns likewise.
    task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             input int stall_n, input int done_dly,
                             input logic [15:0] rdata, input bit late_done);
        exp_t e;
        int   wait_c;
        bit   mis;
        mis   = ALIGN && addr[0];
        e.gap = next_gap;
        if (mis) begin
            m_err    = 1'b1;
            e.freeze = 1;
            e.rd     = 0;
            e.wr     = 0;
        end else begin
            m_addr  = addr;
            m_wdata = wdata;
            e.rd    = we ? 0 : stall_n + 1;
            e.wr    = we ? stall_n + 1 : 0;
            if (done_dly <= TIMEOUT) begin
                wait_c = done_dly;
                if (!we) m_rdata = rdata;
            end else begin
                wait_c = TIMEOUT;
                m_err  = 1'b1;
            end
            e.freeze = 1 + (stall_n + 1) + wait_c;
        end
        e.rdata = m_rdata;
        e.err   = m_err;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        exp_q.push_back(e);

        bus.mem_enable_in   = 1'b1;
        bus.mem_write_en_in = we;
        bus.addr_in         = addr;
        bus.wdata_in        = wdata;
        tick();
        bus.mem_enable_in   = 1'b0;
        bus.addr_in         = 16'($urandom);
        if (!mis) begin
            for (int s = 0; s < stall_n; s++) begin
                bus.mem_stall_in = 1'b1;
                // Stray done pulses while the request is stalled must be ignored.
                bus.mem_done_in  = ($urandom_range(0, 1) == 1);
                bus.mem_rdata_in = 16'($urandom);
                tick();
            end
            bus.mem_stall_in = 1'b0;
            bus.mem_done_in  = 1'b0;
            tick();
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (k == done_dly) begin
                    bus.mem_done_in  = 1'b1;
                    bus.mem_rdata_in = rdata;
                    tick();
                    bus.mem_done_in  = 1'b0;
                    break;
                end
                tick();
            end
            if (late_done) begin
                bus.mem_done_in  = 1'b1;
                bus.mem_rdata_in = 16'($urandom);
            end
        end
        tick();
        bus.mem_done_in = 1'b0;
        next_gap = 1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        bus.mem_enable_in   = 1'b0;
        bus.mem_write_en_in = 1'b0;
        bus.addr_in         = '0;
        bus.wdata_in        = '0;
        bus.mem_stall_in    = 1'b0;
        bus.mem_done_in     = 1'b0;
        bus.mem_rdata_in    = '0;
        #1;
        check("rst_freeze", bus.freeze_out, 0);
        check("rst_rd", bus.mem_rd_out, 0);
        check("rst_wr", bus.mem_wr_out, 0);
        check("rst_err", bus.err_out, 0);
        check("rst_read_data", bus.read_data_out, 0);
        repeat (2) tick();
        global_rst_n = 1'b1;
        tick();

        do_access(1'b0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 1'b0);
        do_access(1'b1, 16'h0020, 16'h1234, 2, 1, 16'hDEAD, 1'b0);
        idle(2);
        do_access(1'b0, 16'h0030, 16'h0000, 0, 1, 16'hA5A5, 1'b0);
        do_access(1'b0, 16'h0032, 16'h0000, 1, 2, 16'h5A5A, 1'b0);
        do_access(1'b0, 16'h0034, 16'h0000, 0, TIMEOUT, 16'hC0DE, 1'b0);
        do_access(1'b0, 16'h0036, 16'h0000, 0, TIMEOUT + 10, 16'hFFFF, 1'b1);
        idle(1);

        // Reset in the middle of WAIT
        bus.mem_enable_in   = 1'b1;
        bus.mem_write_en_in = 1'b0;
        bus.addr_in         = 16'h0040;
        tick();
        bus.mem_enable_in = 1'b0;
        repeat (3) tick();
        #2 global_rst_n = 1'b0;
        #1;
        check("mid_rst_freeze", bus.freeze_out, 0);
        check("mid_rst_rd", bus.mem_rd_out, 0);
        check("mid_rst_addr", bus.mem_addr_out, 0);
        check("mid_rst_wdata", bus.mem_wdata_out, 0);
        check("mid_rst_read_data", bus.read_data_out, 0);
        check("mid_rst_err", bus.err_out, 0);
        repeat (2) tick();
        check("held_rst_rd", bus.mem_rd_out, 0);
        global_rst_n = 1'b1;
        m_rdata = '0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
        next_gap = -1;
        tick();
        check("post_rst_rd_idle", bus.mem_rd_out, 0);

        do_access(1'b0, 16'h0044, 16'h0000, 0, 1, 16'h4444, 1'b0);
        do_access(1'b0, 16'h0011, 16'h0000, 0, 1, 16'h7777, 1'b0);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            bit          we;
            logic [15:0] a;
            logic [15:0] wd;
            logic [15:0] rd;
            int          st;
            int          dd;
            we = ($urandom_range(0, 1) == 1);
            a  = 16'($urandom);
            wd = 16'($urandom);
            rd = 16'($urandom);
            st = $urandom_range(0, 3);
            dd = ($urandom_range(0, 15) == 0) ? TIMEOUT + 5 : $urandom_range(1, 6);
            do_access(we, a, wd, st, dd, rd, ($urandom_range(0, 1) == 1));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
